led_test_logic: RTL and testbench
=================================

Name: led_test_logic

Overview:
- Registered LED driver that evaluates a key-selected logic function of two input signals.
- Inputs a, b and key_in are asynchronous: they come from switches or buttons.
- Each input is synchronised; key_in is also debounced before use.
- Sits at the board-I/O edge, between raw switch/button pins and an LED pin.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops per input; legal values >= 2.
- DEBOUNCE_CNT, 4, consecutive clocks the synchronised key must differ from its stable value before it is accepted. 0 = bypass the debouncer.
- LED_ACTIVE_LOW, 0, output polarity. 1 inverts led_out so that logic-true drives 0.

Ports:
- clk  input  1  single system clock; all state is rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- a  input  1  asynchronous operand A.
- b  input  1  asynchronous operand B.
- key_in  input  1  asynchronous mode key; 1 = pressed.
- led_out  output  1  registered LED drive.

Behaviour:
- One clock domain (clk); reset is asynchronous and active-low (rst_n).
- Reset:
  - Asserting rst_n=0 immediately clears all synchroniser flops, the debounce counter and key_stable to 0.
  - led_out goes to LED_ACTIVE_LOW (LED off).
  - Release is synchronous-safe: the first update occurs on the first clk rise after rst_n=1.
- Synchronisers: a, b and key_in each pass through a SYNC_STAGES-deep flop chain, giving a_s, b_s and key_s.
- Debounce (DEBOUNCE_CNT>0):
  - Counter width is clog2(DEBOUNCE_CNT+1).
  - If key_s==key_stable, the counter clears.
  - Otherwise the counter increments. On the edge where counter==DEBOUNCE_CNT-1 and key_s still differs, key_stable<=key_s and the counter clears.
  - Any return of key_s to key_stable before acceptance clears the counter, so the pulse is rejected.
  - The counter never wraps.
- Debounce bypass (DEBOUNCE_CNT=0): key_stable = key_s combinationally; no counter is instantiated.
- Function:
  - f = key_stable ? (a_s & b_s) : (a_s | b_s).
  - Key released → OR of the operands; key pressed → AND.
- Output: led_out <= f XOR LED_ACTIVE_LOW on every clk rise. Glitch-free (driven directly from a flop).
- Latency:
  - a/b change → led_out after SYNC_STAGES+1 clock edges.
  - Accepted key change → led_out after SYNC_STAGES+DEBOUNCE_CNT+1 edges.
- Simultaneous events:
  - a/b and key changing together: each follows its own latency. One intermediate led_out value is permitted.
  - Reset mid-debounce discards the pending key change.

Decomposition:
- Package led_test_pkg holds:
  - default constants SYNC_STAGES_DEF=2, DEBOUNCE_CNT_DEF=4;
  - a function computing the counter width.
- One natural sub-module, key_debounce: synchroniser plus debounce counter, with outputs key_stable and an optional change strobe. The a/b synchronisers reuse its synchroniser portion with debounce bypassed.
- Top level holds the function mux and the output register.

Test Plan:
- Reset check:
  - Hold rst_n=0 for 5 clocks → led_out=0.
  - Repeat with LED_ACTIVE_LOW=1 → led_out=1.
- Truth-table sweep:
  - Setup: clk period 10 ns, defaults; step {a,b,key_in} through 000→111, holding each 100 ns.
  - Required led_out after settling: 0,0,1,0,1,0,1,1.
- Key glitch rejection:
  - With a=1, b=0, key_in=0, pulse key_in=1 for 2 clocks → led_out stays 1.
  - Hold key_in=1 for 10 clocks → led_out falls to 0 exactly 2+4+1 edges after key_in is sampled.
- Latency check: with key=1, b=1, toggle a 0→1 → led_out rises exactly SYNC_STAGES+1=3 edges later.
- Reset mid-operation:
  - Assert rst_n during a debounce count (counter=2).
  - → led_out=0 asynchronously; key_stable=0 after release even with key_in held 1, until 4 fresh stable clocks elapse.
- Bypass build: DEBOUNCE_CNT=0, key_in 0→1 with a=1, b=0 → led_out 1→0 after 3 edges.

Source files
------------

// File: rtl/led_test_pkg.sv
// Shared constants and helpers for the LED test logic block.
package led_test_pkg;

    localparam int SYNC_STAGES_DEF  = 2;
    localparam int DEBOUNCE_CNT_DEF = 4;

    // Debounce counter width; a zero count still yields a legal 1-bit width.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/led_test_logic_key_debounce.sv
// Multi-flop synchroniser with an optional debounce filter on its output.
import led_test_pkg::*;

module key_debounce #(
    parameter int SYNC_STAGES  = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CNT = DEBOUNCE_CNT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic key_stable
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   key_s;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign key_s = sync_q[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CNT > 0) begin : g_debounce
            localparam int            CW       = cnt_width(DEBOUNCE_CNT);
            localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CNT - 1);

            logic [CW-1:0] cnt_q;
            logic [CW-1:0] cnt_d;
            logic          stable_q;
            logic          stable_d;

            // Accept only after DEBOUNCE_CNT consecutive differing samples;
            // any return to the stable value restarts the count.
            always_comb begin
                cnt_d    = cnt_q;
                stable_d = stable_q;
                if (key_s == stable_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    stable_d = key_s;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q    <= '0;
                    stable_q <= 1'b0;
                end else begin
                    cnt_q    <= cnt_d;
                    stable_q <= stable_d;
                end
            end

            assign key_stable = stable_q;
        end else begin : g_bypass
            assign key_stable = key_s;
        end
    endgenerate

endmodule

// File: rtl/led_test_logic.sv
// Registered LED driver: key selects AND (pressed) or OR (released) of a and b.
import led_test_pkg::*;

module led_test_logic #(
    parameter int SYNC_STAGES    = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CNT   = DEBOUNCE_CNT_DEF,
    parameter bit LED_ACTIVE_LOW = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a,
    input  logic b,
    input  logic key_in,
    output logic led_out
);

    logic a_s;
    logic b_s;
    logic key_stable;
    logic f;
    logic led_d;
    logic led_q;

    key_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CNT(DEBOUNCE_CNT)) u_key (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (key_in),
        .key_stable (key_stable)
    );

    // Operands only need synchronising, so their debounce is bypassed.
    key_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CNT(0)) u_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (a),
        .key_stable (a_s)
    );

    key_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CNT(0)) u_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (b),
        .key_stable (b_s)
    );

    always_comb begin
        f     = key_stable ? (a_s & b_s) : (a_s | b_s);
        led_d = f ^ LED_ACTIVE_LOW;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_q <= LED_ACTIVE_LOW;
        end else begin
            led_q <= led_d;
        end
    end

    assign led_out = led_q;

endmodule

// File: tb/tb_led_test_logic.sv
// Directed bench for led_test_logic: default, active-low and bypass builds side by side.
module tb_led_test_logic;

    logic clk;
    logic rst_n;
    logic a;
    logic b;
    logic key_in;
    logic led;
    logic led_al;
    logic led_bp;

    int n_checks;
    int n_errors;

    led_test_logic dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .key_in(key_in), .led_out(led)
    );

    led_test_logic #(.LED_ACTIVE_LOW(1'b1)) dut_al (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .key_in(key_in), .led_out(led_al)
    );

    led_test_logic #(.DEBOUNCE_CNT(0)) dut_bp (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .key_in(key_in), .led_out(led_bp)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic wait_clocks(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        a      = 1'b1;
        b      = 1'b1;
        key_in = 1'b0;
        wait_clocks(5);
        n_checks++;
        if (led !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_led got %b exp 0", led);
        end
        n_checks++;
        if (led_al !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_led_active_low got %b exp 1", led_al);
        end
        n_checks++;
        if (led_bp !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_led_bypass got %b exp 0", led_bp);
        end
        a     = 1'b0;
        b     = 1'b0;
        rst_n = 1'b1;
        wait_clocks(2);
    endtask

    task automatic test_truth_table();
        logic [7:0] exp_tbl;
        exp_tbl = 8'b1101_0100; // bit v = expected led for {a,b,key_in} = v
        for (int v = 0; v < 8; v++) begin
            {a, b, key_in} = 3'(v);
            wait_clocks(10);
            n_checks++;
            if (led !== exp_tbl[v]) begin
                n_errors++;
                $display("FAIL truth v=%0d led got %b exp %b", v, led, exp_tbl[v]);
            end
            n_checks++;
            if (led_al !== ~exp_tbl[v]) begin
                n_errors++;
                $display("FAIL truth_al v=%0d led got %b exp %b", v, led_al, ~exp_tbl[v]);
            end
            n_checks++;
            if (led_bp !== exp_tbl[v]) begin
                n_errors++;
                $display("FAIL truth_bp v=%0d led got %b exp %b", v, led_bp, exp_tbl[v]);
            end
        end
    endtask

    task automatic test_key_glitch();
        a      = 1'b1;
        b      = 1'b0;
        key_in = 1'b0;
        wait_clocks(10);
        key_in = 1'b1;
        wait_clocks(2);
        key_in = 1'b0;
        for (int i = 0; i < 12; i++) begin
            wait_clocks(1);
            n_checks++;
            if (led !== 1'b1) begin
                n_errors++;
                $display("FAIL glitch_reject cyc=%0d led got %b exp 1", i, led);
            end
        end
        // Held press: falls exactly on edge 7 after key_in is first sampled.
        key_in = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (led !== (e >= 7 ? 1'b0 : 1'b1)) begin
                n_errors++;
                $display("FAIL key_accept edge=%0d led got %b exp %b", e, led, (e >= 7 ? 1'b0 : 1'b1));
            end
        end
        @(negedge clk);
    endtask

    task automatic test_latency();
        key_in = 1'b1;
        b      = 1'b1;
        a      = 1'b0;
        wait_clocks(10);
        n_checks++;
        if (led !== 1'b0) begin
            n_errors++;
            $display("FAIL latency_pre led got %b exp 0", led);
        end
        a = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (led !== (e >= 3 ? 1'b1 : 1'b0)) begin
                n_errors++;
                $display("FAIL ab_latency edge=%0d led got %b exp %b", e, led, (e >= 3 ? 1'b1 : 1'b0));
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        a      = 1'b1;
        b      = 1'b0;
        key_in = 1'b0;
        wait_clocks(10);
        n_checks++;
        if (led !== 1'b1) begin
            n_errors++;
            $display("FAIL mid_pre led got %b exp 1", led);
        end
        key_in = 1'b1;
        wait_clocks(4); // debounce counter now at 2
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (led !== 1'b0) begin
            n_errors++;
            $display("FAIL mid_async_clear led got %b exp 0", led);
        end
        n_checks++;
        if (led_al !== 1'b1) begin
            n_errors++;
            $display("FAIL mid_async_clear_al led got %b exp 1", led_al);
        end
        wait_clocks(2);
        rst_n = 1'b1;
        // Edges 1-2: pipeline refills; 3-6: OR (key still released); 7: AND.
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (led !== ((e >= 3 && e <= 6) ? 1'b1 : 1'b0)) begin
                n_errors++;
                $display("FAIL mid_recover edge=%0d led got %b exp %b", e, led, ((e >= 3 && e <= 6) ? 1'b1 : 1'b0));
            end
        end
        @(negedge clk);
    endtask

    task automatic test_bypass();
        a      = 1'b1;
        b      = 1'b0;
        key_in = 1'b0;
        wait_clocks(10);
        n_checks++;
        if (led_bp !== 1'b1) begin
            n_errors++;
            $display("FAIL bypass_pre led got %b exp 1", led_bp);
        end
        key_in = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (led_bp !== (e >= 3 ? 1'b0 : 1'b1)) begin
                n_errors++;
                $display("FAIL bypass_key edge=%0d led got %b exp %b", e, led_bp, (e >= 3 ? 1'b0 : 1'b1));
            end
        end
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        a        = 1'b0;
        b        = 1'b0;
        key_in   = 1'b0;
        @(negedge clk);
        test_reset();
        test_truth_table();
        test_key_glitch();
        test_latency();
        test_reset_mid();
        test_bypass();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
